// File: rtl/sync_bd_launcher_pkg.sv
// sync_bd_launcher_pkg: shared FSM state encoding for the bundled-data launcher
package sync_bd_launcher_pkg;
   typedef enum logic [2:0] {DRAIN, IDLE, SETUP, REQ_HI, REQ_LO, ERR} state_t;
endpackage

// File: rtl/sync_bd_launcher_sync.sv
// bd_sync_ff: STAGES-deep async-reset synchronizer for a single asynchronous bit
module bd_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] ff;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff <= '0;
      else ff <= {ff[STAGES-2:0], d};
   assign q = ff[STAGES-1];
endmodule

// File: rtl/sync_bd_launcher.sv
// sync_bd_launcher: launches producer words into a 4-phase bundled-data chain,
// measures req->ack round trip and flags a stuck chain by timeout.
module sync_bd_launcher
   import sync_bd_launcher_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SETUP_CYC   = 1,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT     = 200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              outR,
   input  logic              outA,
   output logic [DATA_W-1:0] outData,
   output logic [CNT_W-1:0]  rtt_cycles,
   output logic              rtt_valid,
   output logic              timeout_err,
   input  logic              clr_err
);
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic a_s, accept, launch, ack, tmo, tmo_hit;
   bd_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(outA), .q(a_s));
   assign tmo_hit = cnt == CNT_W'(TIMEOUT - 1);
   assign i_ready = state == IDLE;
   // DRAIN waits for the synchronizer to refill before trusting aS==0
   always_comb begin
      state_nxt = state;
      accept = 1'b0;
      launch = 1'b0;
      ack = 1'b0;
      tmo = 1'b0;
      case (state)
         DRAIN:   if (cnt >= CNT_W'(SYNC_STAGES) && !a_s) state_nxt = IDLE;
         IDLE:    if (i_valid) begin accept = 1'b1; state_nxt = SETUP; end
         SETUP:   if (cnt == CNT_W'(SETUP_CYC - 1)) begin launch = 1'b1; state_nxt = REQ_HI; end
         REQ_HI:  if (tmo_hit) begin tmo = 1'b1; state_nxt = ERR; end
                  else if (a_s) begin ack = 1'b1; state_nxt = REQ_LO; end
         REQ_LO:  if (tmo_hit) begin tmo = 1'b1; state_nxt = ERR; end
                  else if (!a_s) state_nxt = IDLE;
         ERR:     if (clr_err) state_nxt = DRAIN;
         default: state_nxt = DRAIN;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= DRAIN;
         cnt <= '0;
         outR <= 1'b0;
         outData <= '0;
         rtt_cycles <= '0;
         rtt_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= (state_nxt != state) ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
         outR <= launch ? 1'b1 : (ack | tmo) ? 1'b0 : outR;
         rtt_valid <= ack;
         timeout_err <= tmo ? 1'b1 : (state == ERR && clr_err) ? 1'b0 : timeout_err;
         if (accept) outData <= i_data;
         if (ack) rtt_cycles <= cnt;
      end
endmodule

// File: tb/tb_sync_bd_launcher.sv
// tb_sync_bd_launcher: directed bench; chain modelled as outA = outR delayed D cycles
module tb_sync_bd_launcher;
   logic clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, clr_err = 1'b0;
   logic [7:0] i_data = '0;
   logic i_ready, outR, outA, rtt_valid, timeout_err;
   logic [7:0] outData, rtt_cycles;
   logic [7:0] hist = '0;
   logic a_man_en = 1'b1, a_man = 1'b0;
   int d_cyc = 3;
   int n_tests = 0, n_fail = 0, n_rtt = 0;
   logic prev_r = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b0;
   logic [7:0] prev_data = '0;
   logic [7:0] launched[$];

   sync_bd_launcher dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .outR(outR), .outA(outA), .outData(outData), .rtt_cycles(rtt_cycles),
      .rtt_valid(rtt_valid), .timeout_err(timeout_err), .clr_err(clr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) hist <= {hist[6:0], outR};
   assign outA = a_man_en ? a_man : hist[d_cyc-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // outData may only move on the edge after a cycle with i_ready high
   always @(negedge clk) begin
      if (rst_n && prev_rst && outData !== prev_data) chk("data_only_on_accept", 32'(prev_rdy), 1);
      if (outR && !prev_r) launched.push_back(outData);
      if (rtt_valid) n_rtt <= n_rtt + 1;
      prev_r <= outR;
      prev_rdy <= i_ready;
      prev_data <= outData;
      prev_rst <= rst_n;
   end

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!i_ready && k < 60) begin @(negedge clk); k++; end
      chk(tag, 32'(i_ready), 1);
   endtask

   task automatic send(input logic [7:0] w, input logic [7:0] rtt);
      int k = 0;
      i_data = w;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      chk("data_t1", 32'(outData), 32'(w));
      chk("req_low_setup", 32'(outR), 0);
      @(negedge clk);
      chk("req_rise_t2", 32'(outR), 1);
      while (!rtt_valid && k < 50) begin @(negedge clk); k++; end
      chk("rtt_latency", k, 6);
      chk("rtt_value", 32'(rtt_cycles), 32'(rtt));
      chk("req_fall", 32'(outR), 0);
      wait_ready("ready_after_rtz");
      chk("data_held", 32'(outData), 32'(w));
   endtask

   initial begin
      int k, base;
      // 1: reset, outA=0
      repeat (3) @(negedge clk);
      chk("rst_outR", 32'(outR), 0);
      chk("rst_ready", 32'(i_ready), 0);
      chk("rst_data", 32'(outData), 0);
      chk("rst_rtt", 32'(rtt_cycles), 0);
      chk("rst_rttv", 32'(rtt_valid), 0);
      chk("rst_err", 32'(timeout_err), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("drain_ready_low", 32'(i_ready), 0);
      @(negedge clk);
      chk("drain_to_idle", 32'(i_ready), 1);
      // 2: single word through a 3-cycle chain
      a_man_en = 1'b0;
      send(8'hA5, 8'd5);
      // 3: back-to-back words with i_valid held
      launched.delete();
      base = n_rtt;
      for (int w = 1; w <= 16; w++) begin
         i_data = 8'(w);
         i_valid = 1'b1;
         k = 0;
         while (!i_ready && k < 60) begin @(negedge clk); k++; end
         chk("b2b_ready", 32'(i_ready), 1);
         @(negedge clk);
         chk("b2b_data", 32'(outData), 32'(w));
      end
      i_valid = 1'b0;
      wait_ready("b2b_done");
      chk("b2b_count", launched.size(), 16);
      chk("b2b_rtt_pulses", n_rtt - base, 16);
      for (int i = 0; i < launched.size(); i++) chk("b2b_order", 32'(launched[i]), i + 1);
      // 4: stuck chain -> timeout, clear, recover
      a_man_en = 1'b1;
      a_man = 1'b0;
      i_data = 8'h3C;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      chk("tmo_req_rise", 32'(outR), 1);
      repeat (199) @(negedge clk);
      chk("tmo_not_yet", 32'(timeout_err), 0);
      @(negedge clk);
      chk("tmo_err", 32'(timeout_err), 1);
      chk("tmo_outR", 32'(outR), 0);
      chk("tmo_ready", 32'(i_ready), 0);
      repeat (3) @(negedge clk);
      chk("tmo_sticky", 32'(timeout_err), 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err", 32'(timeout_err), 0);
      wait_ready("clr_to_idle");
      a_man_en = 1'b0;
      send(8'h77, 8'd5);
      // 5: reset mid-handshake with outA high
      a_man_en = 1'b1;
      a_man = 1'b0;
      i_data = 8'h5A;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      a_man = 1'b1;
      @(negedge clk);
      chk("mid_req_high", 32'(outR), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_outR", 32'(outR), 0);
      chk("async_rst_data", 32'(outData), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("drain_waits_ack", 32'(i_ready), 0);
      a_man = 1'b0;
      wait_ready("drain_after_rtz");
      // 6: outA glitch and stray clr_err in IDLE
      base = n_rtt;
      a_man = 1'b1;
      @(negedge clk);
      a_man = 1'b0;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch_ready", 32'(i_ready), 1);
      chk("glitch_no_rtt", n_rtt - base, 0);
      chk("glitch_outR", 32'(outR), 0);
      chk("glitch_err", 32'(timeout_err), 0);
      a_man_en = 1'b0;
      send(8'hC3, 8'd5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
